// File: rtl/obg_frame_ctrl_if.sv
// Control/status bundle between the OBG frame sequencer and its environment.
interface obg_frame_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  // run control and configuration
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_num_frames;
  logic [3:0]       cfg_type;
  logic [15:0]      cfg_len;
  // feedback from OBG / payload side
  logic             ssg_do_vld;
  logic             pld_done;
  // towards OBG
  logic [3:0]       ssg_di_type;
  logic [15:0]      ssg_di_len;
  logic             ssg_di_vld;
  logic             new_frame;
  logic             obg_rst;
  // status
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;
  logic             done;
  logic             err;

  modport master (
    output start, abort, cfg_num_frames, cfg_type, cfg_len, ssg_do_vld, pld_done,
    input  ssg_di_type, ssg_di_len, ssg_di_vld, new_frame, obg_rst, busy, frame_cnt, done, err
  );

  modport slave (
    input  start, abort, cfg_num_frames, cfg_type, cfg_len, ssg_do_vld, pld_done,
    output ssg_di_type, ssg_di_len, ssg_di_vld, new_frame, obg_rst, busy, frame_cnt, done, err
  );
endinterface

// File: rtl/obg_frame_ctrl.sv
// OBG frame sequencer: issues SIGNAL fields, counts SIGNAL bits, waits for the
// payload, then holds OBG in reset for an inter-frame gap, for N frames per run.
module obg_frame_ctrl #(
  parameter int unsigned SIG_BITS   = 24,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 4095,
  parameter int unsigned CNT_W      = 8
) (
  input  logic            ssg_clk,
  input  logic            ssg_rst,
  obg_frame_ctrl_if.slave bus
);

  localparam int unsigned SIG_W = (SIG_BITS   > 1) ? $clog2(SIG_BITS)   : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TMO_W = (TIMEOUT    > 1) ? $clog2(TIMEOUT)    : 1;

  localparam logic [SIG_W-1:0] SIG_LAST = SIG_W'(SIG_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_SIG,
    S_WAIT_PLD,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic [3:0]       r_type;
  logic [15:0]      r_len;
  logic [SIG_W-1:0] r_sig_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_abort_pend;
  logic [3:0]       r_di_type;
  logic [15:0]      r_di_len;
  logic             r_di_vld;
  logic             r_new_frame;
  logic             r_obg_rst;
  logic             r_busy;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_done;
  logic             r_err;

  logic [CNT_W-1:0] w_frame_cnt_inc;
  logic             w_abortable;

  assign w_frame_cnt_inc = r_frame_cnt + CNT_W'(1);
  // abort forces an early gap only while a frame is being set up or transferred
  assign w_abortable = (r_state == S_LOAD) || (r_state == S_ISSUE) ||
                       (r_state == S_SIG)  || (r_state == S_WAIT_PLD);

  // Sequencer state, counters and registered outputs
  always_ff @(posedge ssg_clk or posedge ssg_rst) begin
    if (ssg_rst) begin
      r_state      <= S_IDLE;
      r_num        <= '0;
      r_type       <= '0;
      r_len        <= '0;
      r_sig_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_tmo_cnt    <= '0;
      r_abort_pend <= 1'b0;
      r_di_type    <= '0;
      r_di_len     <= '0;
      r_di_vld     <= 1'b0;
      r_new_frame  <= 1'b0;
      r_obg_rst    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_cnt  <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_di_vld    <= 1'b0;
      r_new_frame <= 1'b0;
      r_done      <= 1'b0;
      if (bus.abort && w_abortable) begin
        r_err        <= 1'b1;
        r_abort_pend <= 1'b1;
        r_obg_rst    <= 1'b1;
        r_gap_cnt    <= '0;
        r_state      <= S_GAP;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.cfg_num_frames != '0) begin
                r_num        <= bus.cfg_num_frames;
                r_type       <= bus.cfg_type;
                r_len        <= bus.cfg_len;
                r_frame_cnt  <= '0;
                r_err        <= 1'b0;
                r_abort_pend <= 1'b0;
                r_busy       <= 1'b1;
                r_state      <= S_LOAD;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            r_di_type <= r_type;
            r_di_len  <= r_len;
            r_state   <= S_ISSUE;
          end
          S_ISSUE: begin
            r_di_vld    <= 1'b1;
            r_new_frame <= 1'b1;
            r_sig_cnt   <= '0;
            r_state     <= S_SIG;
          end
          S_SIG: begin
            if (bus.ssg_do_vld) begin
              if (r_sig_cnt == SIG_LAST) begin
                r_tmo_cnt <= '0;
                r_state   <= S_WAIT_PLD;
              end else begin
                r_sig_cnt <= r_sig_cnt + SIG_W'(1);
              end
            end
          end
          S_WAIT_PLD: begin
            if (bus.pld_done) begin
              r_obg_rst <= 1'b1;
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end else if (r_tmo_cnt == TMO_LAST) begin
              r_err     <= 1'b1;
              r_obg_rst <= 1'b1;
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
          end
          S_GAP: begin
            if (bus.abort) begin
              r_abort_pend <= 1'b1;
            end
            if (r_gap_cnt == GAP_LAST) begin
              r_obg_rst   <= 1'b0;
              r_frame_cnt <= w_frame_cnt_inc;
              if ((w_frame_cnt_inc == r_num) || r_abort_pend || bus.abort) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_LOAD;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ssg_di_type = r_di_type;
  assign bus.ssg_di_len  = r_di_len;
  assign bus.ssg_di_vld  = r_di_vld;
  assign bus.new_frame   = r_new_frame;
  assign bus.obg_rst     = r_obg_rst;
  assign bus.busy        = r_busy;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_obg_frame_ctrl.sv
// Bench for obg_frame_ctrl: scenario tasks with a frame-level expectation model.
module tb_obg_frame_ctrl;

  localparam int SIG_BITS = 24;
  localparam int GAP      = 16;
  localparam int TMO      = 4095;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  obg_frame_ctrl_if #(.CNT_W(8)) bus ();

  obg_frame_ctrl #(
    .SIG_BITS  (SIG_BITS),
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO),
    .CNT_W     (8)
  ) dut (
    .ssg_clk(clk),
    .ssg_rst(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // observed-event log, sampled on the falling edge
  int          vld_hi = 0;
  int          nf_hi = 0;
  int          coinc_bad = 0;
  int          done_hi = 0;
  int          rst_run = 0;
  int          gap_q[$];
  int          fc_q[$];
  logic [3:0]  vt_q[$];
  logic [3:0]  vt_prev_q[$];
  logic [15:0] vl_q[$];
  logic [15:0] vl_prev_q[$];
  logic [3:0]  prev_type = '0;
  logic [15:0] prev_len = '0;
  logic [7:0]  last_fc = '0;

  always @(negedge clk) begin
    if (bus.ssg_di_vld === 1'b1) begin
      vld_hi++;
      vt_q.push_back(bus.ssg_di_type);
      vl_q.push_back(bus.ssg_di_len);
      vt_prev_q.push_back(prev_type);
      vl_prev_q.push_back(prev_len);
    end
    if (bus.new_frame === 1'b1) nf_hi++;
    if (bus.new_frame !== bus.ssg_di_vld) coinc_bad++;
    if (bus.done === 1'b1) done_hi++;
    if (bus.obg_rst === 1'b1) rst_run++;
    else if (rst_run != 0) begin
      gap_q.push_back(rst_run);
      rst_run = 0;
    end
    if (bus.frame_cnt !== last_fc) begin
      if (bus.frame_cnt != 8'd0) fc_q.push_back(int'(bus.frame_cnt));
      last_fc = bus.frame_cnt;
    end
    prev_type = bus.ssg_di_type;
    prev_len  = bus.ssg_di_len;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    vld_hi = 0; nf_hi = 0; coinc_bad = 0; done_hi = 0;
    gap_q.delete(); fc_q.delete();
    vt_q.delete(); vt_prev_q.delete(); vl_q.delete(); vl_prev_q.delete();
  endtask

  function automatic logic [33:0] outs_vec();
    return {bus.ssg_di_type, bus.ssg_di_len, bus.ssg_di_vld, bus.new_frame, bus.obg_rst,
            bus.busy, bus.frame_cnt, bus.done, bus.err};
  endfunction

  task automatic do_start(input logic [7:0] n, input logic [3:0] t, input logic [15:0] l);
    bus.cfg_num_frames = n;
    bus.cfg_type       = t;
    bus.cfg_len        = l;
    bus.start          = 1'b1;
    tick();
    bus.start          = 1'b0;
  endtask

  task automatic wait_gap_end(output bit ok);
    int n = 0;
    while (bus.obg_rst === 1'b1 && n < GAP + 4) begin
      tick();
      n++;
    end
    ok = (bus.obg_rst === 1'b0);
  endtask

  // Plays the OBG/payload side of one frame. abort_at<0: no abort; pld_delay<0: no pld_done.
  task automatic drive_frame(input int abort_at, input int pld_delay, input bit spurious,
                             input bit gap_abort, output bit ok, output bit spur_rst,
                             output bit rst_on_time);
    int n = 0;
    ok = 1'b1; spur_rst = 1'b0; rst_on_time = 1'b0;
    while (bus.ssg_di_vld !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (bus.ssg_di_vld !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < SIG_BITS; i++) begin
      if (i == abort_at) begin
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        rst_on_time = bus.obg_rst;
        wait_gap_end(ok);
        return;
      end
      repeat ($urandom_range(0, 3)) tick();
      if (spurious && i == SIG_BITS - 1) begin
        bus.pld_done = 1'b1; tick(); bus.pld_done = 1'b0;
        spur_rst = bus.obg_rst;
      end
      bus.ssg_do_vld = 1'b1; tick(); bus.ssg_do_vld = 1'b0;
    end
    if (pld_delay < 0) return;
    repeat (pld_delay) tick();
    bus.pld_done = 1'b1; tick(); bus.pld_done = 1'b0;
    rst_on_time = bus.obg_rst;
    if (gap_abort) begin
      repeat (5) tick();
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    end
    wait_gap_end(ok);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (outs_vec() !== 34'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", outs_vec());
    end
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if (outs_vec() !== 34'd0) begin
      bad++; $display("FAIL idle_after_reset: got %h want 0", outs_vec());
    end
  endtask

  task automatic test_single_frame();
    bit ok, spur, rot;
    clear_mon();
    do_start(8'd1, 4'hB, 16'd100);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    drive_frame(-1, 3, 1'b1, 1'b0, ok, spur, rot);
    repeat (2) tick();
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL single_handshake: got %b want 1", ok); end
    total++;
    if (spur !== 1'b0) begin bad++; $display("FAIL single_pld_in_sig: obg_rst got %b want 0", spur); end
    total++;
    if (rot !== 1'b1) begin bad++; $display("FAIL single_gap_entry: obg_rst got %b want 1", rot); end
    total++;
    if (vld_hi !== 1 || nf_hi !== 1 || coinc_bad !== 0) begin
      bad++; $display("FAIL single_strobes: vld=%0d nf=%0d split=%0d want 1 1 0", vld_hi, nf_hi, coinc_bad);
    end
    total++;
    if (vt_q.size() != 1 || vt_q[0] !== 4'hB || vt_prev_q[0] !== 4'hB ||
        vl_q[0] !== 16'd100 || vl_prev_q[0] !== 16'd100) begin
      bad++; $display("FAIL single_type_len: vld events=%0d want type b len 100 stable a cycle early", vt_q.size());
    end
    total++;
    if (gap_q.size() != 1 || gap_q[0] != GAP) begin
      bad++; $display("FAIL single_gap_len: count=%0d first=%0d want 1 x %0d", gap_q.size(),
                      (gap_q.size() > 0) ? gap_q[0] : -1, GAP);
    end
    total++;
    if (done_hi !== 1 || bus.frame_cnt !== 8'd1 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL single_end: done=%0d fc=%0d err=%b busy=%b want 1 1 0 0",
                      done_hi, bus.frame_cnt, bus.err, bus.busy);
    end
    total++;
    if (bus.ssg_di_type !== 4'hB || bus.ssg_di_len !== 16'd100) begin
      bad++; $display("FAIL single_hold: type=%h len=%0d want b 100", bus.ssg_di_type, bus.ssg_di_len);
    end
  endtask

  task automatic test_multi_frame();
    bit ok, spur, rot;
    logic [3:0]  t = 4'($urandom);
    logic [15:0] l = 16'($urandom);
    clear_mon();
    do_start(8'd3, t, l);
    bus.cfg_type = ~t; bus.cfg_len = ~l; bus.cfg_num_frames = 8'd1;
    for (int f = 0; f < 3; f++) begin
      drive_frame(-1, int'($urandom_range(0, 20)), 1'b0, 1'b0, ok, spur, rot);
      total++;
      if (ok !== 1'b1 || rot !== 1'b1) begin
        bad++; $display("FAIL multi_frame%0d_handshake: ok=%b gap_entry=%b want 1 1", f, ok, rot);
      end
      if (f < 2) begin
        total++;
        if (done_hi !== 0) begin bad++; $display("FAIL multi_early_done: got %0d want 0", done_hi); end
      end
    end
    repeat (2) tick();
    total++;
    if (vld_hi !== 3 || coinc_bad !== 0) begin
      bad++; $display("FAIL multi_issue_count: got %0d split=%0d want 3 0", vld_hi, coinc_bad);
    end
    total++;
    if (fc_q.size() != 3 || fc_q[0] != 1 || fc_q[1] != 2 || fc_q[2] != 3) begin
      bad++; $display("FAIL multi_frame_cnt_steps: got %0d steps want 1,2,3", fc_q.size());
    end
    for (int i = 0; i < gap_q.size(); i++) begin
      total++;
      if (gap_q[i] != GAP) begin bad++; $display("FAIL multi_gap%0d: got %0d want %0d", i, gap_q[i], GAP); end
    end
    for (int i = 0; i < vt_q.size(); i++) begin
      total++;
      if (vt_q[i] !== t || vl_q[i] !== l || vt_prev_q[i] !== t || vl_prev_q[i] !== l) begin
        bad++; $display("FAIL multi_latched_cfg%0d: type=%h len=%h want %h %h", i, vt_q[i], vl_q[i], t, l);
      end
    end
    total++;
    if (gap_q.size() != 3 || done_hi !== 1 || bus.err !== 1'b0) begin
      bad++; $display("FAIL multi_end: gaps=%0d done=%0d err=%b want 3 1 0", gap_q.size(), done_hi, bus.err);
    end
  endtask

  task automatic test_timeout();
    bit ok, spur, rot;
    int n;
    clear_mon();
    do_start(8'd1, 4'h3, 16'd7);
    drive_frame(-1, -1, 1'b0, 1'b0, ok, spur, rot);
    n = 0;
    while (bus.obg_rst !== 1'b1 && n < TMO + 10) begin tick(); n++; end
    total++;
    if (n != TMO) begin bad++; $display("FAIL timeout_len: got %0d want %0d", n, TMO); end
    total++;
    if (bus.err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", bus.err); end
    wait_gap_end(ok);
    repeat (2) tick();
    total++;
    if (ok !== 1'b1 || done_hi !== 1 || bus.frame_cnt !== 8'd1 || bus.err !== 1'b1) begin
      bad++; $display("FAIL timeout_end: ok=%b done=%0d fc=%0d err=%b want 1 1 1 1",
                      ok, done_hi, bus.frame_cnt, bus.err);
    end
  endtask

  // pld_done on the expiring cycle (wins) and one cycle later (too late)
  task automatic test_timeout_boundary();
    bit ok, spur, rot;
    for (int late = 0; late < 2; late++) begin
      clear_mon();
      do_start(8'd1, 4'h5, 16'd9);
      drive_frame(-1, -1, 1'b0, 1'b0, ok, spur, rot);
      repeat (TMO - 1 + late) tick();
      bus.pld_done = 1'b1; tick(); bus.pld_done = 1'b0;
      total++;
      if (bus.err !== 1'(late) || bus.obg_rst !== 1'b1) begin
        bad++; $display("FAIL timeout_edge_late%0d: err=%b obg_rst=%b want %0d 1", late, bus.err, bus.obg_rst, late);
      end
      wait_gap_end(ok);
      repeat (2) tick();
      total++;
      if (done_hi !== 1 || bus.err !== 1'(late) || gap_q.size() != 1 || gap_q[0] != GAP) begin
        bad++; $display("FAIL timeout_edge_end%0d: done=%0d err=%b gaps=%0d", late, done_hi, bus.err, gap_q.size());
      end
    end
  endtask

  task automatic test_abort();
    bit ok, spur, rot;
    clear_mon();
    do_start(8'd5, 4'h9, 16'd55);
    drive_frame(-1, 2, 1'b0, 1'b0, ok, spur, rot);
    drive_frame(int'($urandom_range(0, SIG_BITS - 1)), 0, 1'b0, 1'b0, ok, spur, rot);
    repeat (2) tick();
    total++;
    if (ok !== 1'b1 || rot !== 1'b1) begin bad++; $display("FAIL abort_gap_entry: ok=%b rst=%b want 1 1", ok, rot); end
    total++;
    if (done_hi !== 1 || bus.frame_cnt !== 8'd2 || bus.err !== 1'b1 || bus.busy !== 1'b0 || vld_hi !== 2) begin
      bad++; $display("FAIL abort_end: done=%0d fc=%0d err=%b busy=%b vld=%0d want 1 2 1 0 2",
                      done_hi, bus.frame_cnt, bus.err, bus.busy, vld_hi);
    end
    total++;
    if (gap_q.size() != 2 || gap_q[1] != GAP) begin
      bad++; $display("FAIL abort_gap_len: gaps=%0d want 2 of %0d", gap_q.size(), GAP);
    end
    clear_mon();
    do_start(8'd3, 4'h2, 16'd1);
    total++;
    if (bus.err !== 1'b0 || bus.frame_cnt !== 8'd0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL abort_restart: err=%b fc=%0d busy=%b want 0 0 1", bus.err, bus.frame_cnt, bus.busy);
    end
    drive_frame(-1, 1, 1'b0, 1'b1, ok, spur, rot);
    repeat (2) tick();
    total++;
    if (ok !== 1'b1 || gap_q.size() != 1 || gap_q[0] != GAP || done_hi !== 1 ||
        bus.frame_cnt !== 8'd1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL abort_in_gap: ok=%b gaps=%0d done=%0d fc=%0d busy=%b want 1 1 1 1 0",
                      ok, gap_q.size(), done_hi, bus.frame_cnt, bus.busy);
    end
  endtask

  task automatic test_zero_busy_reset();
    bit ok, spur, rot;
    clear_mon();
    do_start(8'd0, 4'h1, 16'd1);
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL zero_done: done=%b busy=%b want 1 0", bus.done, bus.busy);
    end
    repeat (4) tick();
    total++;
    if (done_hi !== 1 || vld_hi !== 0) begin
      bad++; $display("FAIL zero_only_done: done=%0d vld=%0d want 1 0", done_hi, vld_hi);
    end
    clear_mon();
    do_start(8'd2, 4'hC, 16'd300);
    bus.cfg_type = 4'h6; bus.cfg_len = 16'd999;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    drive_frame(-1, -1, 1'b0, 1'b0, ok, spur, rot);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (10) tick();
    total++;
    if (vld_hi !== 1 || bus.ssg_di_type !== 4'hC || bus.ssg_di_len !== 16'd300 ||
        bus.busy !== 1'b1 || bus.obg_rst !== 1'b0) begin
      bad++; $display("FAIL busy_start_ignored: vld=%0d type=%h len=%0d busy=%b rst=%b want 1 c 300 1 0",
                      vld_hi, bus.ssg_di_type, bus.ssg_di_len, bus.busy, bus.obg_rst);
    end
    rst = 1'b1;
    #2;
    total++;
    if (outs_vec() !== 34'd0) begin bad++; $display("FAIL midrun_reset: got %h want 0", outs_vec()); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if (done_hi !== 0 || outs_vec() !== 34'd0) begin
      bad++; $display("FAIL midrun_reset_no_done: done=%0d outs=%h want 0 0", done_hi, outs_vec());
    end
  endtask

  task automatic test_random_runs();
    bit ok, spur, rot;
    for (int r = 0; r < 4; r++) begin
      int n  = int'($urandom_range(1, 4));
      bit ab = 1'($urandom_range(0, 1));
      int k  = ab ? int'($urandom_range(1, n)) : 0;
      int fc_exp = ab ? k : n;
      logic [3:0]  t = 4'($urandom);
      logic [15:0] l = 16'($urandom);
      clear_mon();
      do_start(8'(n), t, l);
      for (int f = 1; f <= n; f++) begin
        if (ab && f == k) begin
          drive_frame(int'($urandom_range(0, SIG_BITS - 1)), 0, 1'b0, 1'b0, ok, spur, rot);
        end else begin
          drive_frame(-1, int'($urandom_range(0, 12)), 1'b0, 1'b0, ok, spur, rot);
        end
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL rand%0d_frame%0d_handshake: got 0 want 1", r, f); end
        if (ab && f == k) break;
      end
      repeat (2) tick();
      total++;
      if (done_hi !== 1 || bus.frame_cnt !== 8'(fc_exp) || bus.err !== ab || vld_hi !== fc_exp) begin
        bad++; $display("FAIL rand%0d_end: done=%0d fc=%0d err=%b vld=%0d want 1 %0d %0d %0d",
                        r, done_hi, bus.frame_cnt, bus.err, vld_hi, fc_exp, ab, fc_exp);
      end
      total++;
      if (gap_q.size() != fc_exp || fc_q.size() != fc_exp) begin
        bad++; $display("FAIL rand%0d_counts: gaps=%0d steps=%0d want %0d", r, gap_q.size(), fc_q.size(), fc_exp);
      end else begin
        for (int j = 0; j < fc_exp; j++) begin
          total++;
          if (gap_q[j] != GAP || fc_q[j] != j + 1 || vt_q[j] !== t || vl_q[j] !== l) begin
            bad++; $display("FAIL rand%0d_frame%0d: gap=%0d fc=%0d type=%h len=%h want %0d %0d %h %h",
                            r, j, gap_q[j], fc_q[j], vt_q[j], vl_q[j], GAP, j + 1, t, l);
          end
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_num_frames = '0; bus.cfg_type = '0;
    bus.cfg_len = '0; bus.ssg_do_vld = 1'b0; bus.pld_done = 1'b0;
    test_reset();
    test_single_frame();
    test_multi_frame();
    test_timeout();
    test_timeout_boundary();
    test_abort();
    test_zero_busy_reset();
    test_random_runs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
